spc7110_alu_seq: RTL

Sequencer for the SPC7110 math unit: accepts multiply/divide triggers decoded from the SFC port writes and runs an iterative shift-add / shift-subtract engine under FSM control. It handles signed pre/post correction and pads each operation to a fixed, hardware-faithful latency. It latches 32-bit result and 16-bit remainder and drives the busy flag used for the status port. It sits between the SFC register file (operand/trigger decode) and the result/status read mux.

---
 rtl/spc7110_alu_seq.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/spc7110_alu_seq.sv
// SPC7110 math-unit sequencer: iterative shift-add multiply and restoring
// divide with signed pre/post correction, padded to a fixed latency.
module spc7110_alu_seq #(
   parameter int MUL_LATENCY = 30,
   parameter int DIV_LATENCY = 40
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        start_mul,
   input  logic        start_div,
   input  logic        clear,
   input  logic        signed_mode,
   input  logic [31:0] op_a,
   input  logic [15:0] op_mul,
   input  logic [15:0] op_div,
   output logic        busy,
   output logic        done,
   output logic        last_div,
   output logic [31:0] result,
   output logic [15:0] remainder
);

   localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_PREP, S_MUL_RUN, S_DIV_RUN, S_FIX, S_WAIT
   } state_t;

   // control flops (reset)
   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [4:0]         iter_q, iter_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               last_div_q, last_div_d;
   logic [31:0]        result_q, result_d;
   logic [15:0]        remainder_q, remainder_d;

   // datapath flops (no reset needed)
   logic               div_q, div_d;
   logic               signed_q, signed_d;
   logic               sgn_res_q, sgn_res_d;
   logic               sgn_a_q, sgn_a_d;
   logic               div0_q, div0_d;
   logic [31:0]        opa_q, opa_d;        // multiplicand (low half) / dividend shifter
   logic [15:0]        opb_q, opb_d;        // multiplier shifter / divisor magnitude
   logic [15:0]        raw_lo_q, raw_lo_d;  // unmodified op_a[15:0] for divide-by-zero remainder
   logic [31:0]        acc_q, acc_d;        // product accumulator / quotient shifter
   logic [16:0]        rem_q, rem_d;        // partial remainder
   logic [31:0]        res_hold_q, res_hold_d;
   logic [15:0]        rem_hold_q, rem_hold_d;

   // combinational scratch
   logic               is_div;
   logic               a_neg, b_neg;
   logic [16:0]        shifted;
   logic               qbit;
   logic [31:0]        fix_res;
   logic [15:0]        fix_rem;

   // Next-state and datapath: priority clear > start_div > start_mul, then FSM step
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      iter_d      = iter_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      last_div_d  = last_div_q;
      result_d    = result_q;
      remainder_d = remainder_q;
      div_d       = div_q;
      signed_d    = signed_q;
      sgn_res_d   = sgn_res_q;
      sgn_a_d     = sgn_a_q;
      div0_d      = div0_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      raw_lo_d    = raw_lo_q;
      acc_d       = acc_q;
      rem_d       = rem_q;
      res_hold_d  = res_hold_q;
      rem_hold_d  = rem_hold_q;
      is_div      = start_div;
      a_neg       = 1'b0;
      b_neg       = 1'b0;
      shifted     = {rem_q[15:0], opa_q[31]};
      qbit        = 1'b0;
      fix_res     = 32'h0;
      fix_rem     = 16'h0;

      if (clear) begin
         state_d     = S_IDLE;
         busy_d      = 1'b0;
         result_d    = 32'h0;
         remainder_d = 16'h0;
      end else if (start_mul || start_div) begin
         // a new start always aborts whatever is running and restarts the latency
         state_d    = S_PREP;
         busy_d     = 1'b1;
         last_div_d = is_div;
         div_d      = is_div;
         signed_d   = signed_mode;
         opa_d      = is_div ? op_a : {16'h0, op_a[15:0]};
         opb_d      = is_div ? op_div : op_mul;
         cnt_d      = is_div ? DIV_LOAD : MUL_LOAD;
      end else begin
         if (state_q != S_IDLE) cnt_d = cnt_q - CNT_ONE;
         case (state_q)
            S_PREP: begin
               a_neg     = signed_q & (div_q ? opa_q[31] : opa_q[15]);
               b_neg     = signed_q & opb_q[15];
               sgn_a_d   = a_neg;
               sgn_res_d = a_neg ^ b_neg;
               raw_lo_d  = opa_q[15:0];
               div0_d    = (opb_q == 16'h0);
               if (div_q) opa_d = a_neg ? -opa_q : opa_q;
               else       opa_d = {16'h0, (a_neg ? -opa_q[15:0] : opa_q[15:0])};
               opb_d     = b_neg ? -opb_q : opb_q;
               acc_d     = 32'h0;
               rem_d     = 17'h0;
               iter_d    = 5'd0;
               state_d   = div_q ? S_DIV_RUN : S_MUL_RUN;
            end
            S_MUL_RUN: begin
               // MSB-first shift-add over the 16 multiplier bits
               acc_d  = {acc_q[30:0], 1'b0} + (opb_q[15] ? {16'h0, opa_q[15:0]} : 32'h0);
               opb_d  = {opb_q[14:0], 1'b0};
               iter_d = iter_q + 5'd1;
               if (iter_q == 5'd15) state_d = S_FIX;
            end
            S_DIV_RUN: begin
               // restoring step: bring in next dividend bit, subtract if it fits
               opa_d = {opa_q[30:0], 1'b0};
               if (shifted >= {1'b0, opb_q}) begin
                  rem_d = shifted - {1'b0, opb_q};
                  qbit  = 1'b1;
               end else begin
                  rem_d = shifted;
               end
               acc_d  = {acc_q[30:0], qbit};
               iter_d = iter_q + 5'd1;
               if (iter_q == 5'd31) state_d = S_FIX;
            end
            S_FIX: begin
               if (div_q && div0_q)  fix_res = 32'h0;
               else if (sgn_res_q)   fix_res = -acc_q;
               else                  fix_res = acc_q;
               if (!div_q)           fix_rem = 16'h0;
               else if (div0_q)      fix_rem = raw_lo_q;
               else if (sgn_a_q)     fix_rem = -rem_q[15:0];
               else                  fix_rem = rem_q[15:0];
               res_hold_d = fix_res;
               rem_hold_d = fix_rem;
               // at minimum latency the fixed value commits straight from here
               if (cnt_q == CNT_ONE) begin
                  result_d    = fix_res;
                  remainder_d = fix_rem;
                  done_d      = 1'b1;
                  busy_d      = 1'b0;
                  state_d     = S_IDLE;
               end else begin
                  state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt_q == CNT_ONE) begin
                  result_d    = res_hold_q;
                  remainder_d = rem_hold_q;
                  done_d      = 1'b1;
                  busy_d      = 1'b0;
                  state_d     = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Register update: RESET clears control and visible outputs, datapath just follows
   always_ff @(posedge CLK) begin
      div_q      <= div_d;
      signed_q   <= signed_d;
      sgn_res_q  <= sgn_res_d;
      sgn_a_q    <= sgn_a_d;
      div0_q     <= div0_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      raw_lo_q   <= raw_lo_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      res_hold_q <= res_hold_d;
      rem_hold_q <= rem_hold_d;
      if (RESET) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         iter_q      <= 5'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         last_div_q  <= 1'b0;
         result_q    <= 32'h0;
         remainder_q <= 16'h0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         iter_q      <= iter_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         last_div_q  <= last_div_d;
         result_q    <= result_d;
         remainder_q <= remainder_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign last_div  = last_div_q;
   assign result    = result_q;
   assign remainder = remainder_q;

endmodule
